// File: rtl/instr_register_pipe_pkg.sv
// Shared types and default sizes for the pipelined instruction register.
// Optional saturation is enabled with `define IR_SATURATE_EN.
package instr_register_pipe_pkg;

    localparam int DEF_DEPTH     = 32;
    localparam int DEF_OPERAND_W = 32;
    localparam int DEF_RESULT_W  = 64;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [DEF_OPERAND_W-1:0] operand_t;
    typedef logic signed [DEF_RESULT_W-1:0]  result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  rslt;
    } instruction_t;

    // Codes 8-15 are reserved.
    function automatic logic is_reserved(input opcode_t o);
        return o[3];
    endfunction

endpackage

// File: rtl/instr_register_pipe_alu.sv
// Stage-2 combinational ALU: result plus divide-by-zero / illegal flags.
// With IR_SATURATE_EN, ADD/SUB/MULT clamp to the signed operand range.
import instr_register_pipe_pkg::*;

module ir_alu #(
    parameter int OPERAND_W = DEF_OPERAND_W,
    parameter int RESULT_W  = DEF_RESULT_W
) (
    input  opcode_t                     opc,
    input  logic signed [OPERAND_W-1:0] op_a,
    input  logic signed [OPERAND_W-1:0] op_b,
    output logic signed [RESULT_W-1:0]  rslt,
    output logic                        div0,
    output logic                        illegal
);

    localparam int EXT_W = RESULT_W - OPERAND_W;

`ifdef IR_SATURATE_EN
    localparam logic signed [RESULT_W-1:0] SAT_MAX =
        {{(EXT_W+1){1'b0}}, {(OPERAND_W-1){1'b1}}};
    localparam logic signed [RESULT_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    logic signed [RESULT_W-1:0] a_x;
    logic signed [RESULT_W-1:0] b_x;
    logic signed [RESULT_W-1:0] raw;

    assign a_x = {{EXT_W{op_a[OPERAND_W-1]}}, op_a};
    assign b_x = {{EXT_W{op_b[OPERAND_W-1]}}, op_b};

    always_comb begin
        raw     = '0;
        div0    = 1'b0;
        illegal = 1'b0;
        if (is_reserved(opc)) begin
            illegal = 1'b1;
        end else begin
            case (opc)
                ZERO:  raw = '0;
                PASSA: raw = a_x;
                PASSB: raw = b_x;
                ADD:   raw = a_x + b_x;
                SUB:   raw = a_x - b_x;
                MULT:  raw = a_x * b_x;
                DIV: begin
                    if (b_x == '0) div0 = 1'b1;
                    else           raw  = a_x / b_x;
                end
                MOD: begin
                    if (b_x == '0) div0 = 1'b1;
                    else           raw  = a_x % b_x;
                end
                default: illegal = 1'b1;
            endcase
        end
        rslt = raw;
`ifdef IR_SATURATE_EN
        if (opc inside {ADD, SUB, MULT}) begin
            if (raw > SAT_MAX) begin
                rslt    = SAT_MAX;
                illegal = 1'b1;
            end else if (raw < SAT_MIN) begin
                rslt    = SAT_MIN;
                illegal = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/instr_register_pipe.sv
// Two-stage instruction register: capture, then compute and write.
// Registered reads with write bypass; IR_SATURATE_EN selects saturating ALU.
import instr_register_pipe_pkg::*;

module instr_register_pipe #(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int OPERAND_W = DEF_OPERAND_W,
    parameter int RESULT_W  = DEF_RESULT_W,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_en,
    input  logic                        wr_mode,
    input  opcode_t                     opcode,
    input  logic signed [OPERAND_W-1:0] operand_a,
    input  logic signed [OPERAND_W-1:0] operand_b,
    input  logic [ADDR_W-1:0]           write_pointer,
    input  logic                        read_en,
    input  logic [ADDR_W-1:0]           read_pointer,
    output instruction_t                instruction_word,
    output logic                        rd_valid,
    output logic                        rd_entry_valid,
    output logic [ADDR_W-1:0]           wr_cnt,
    output logic                        err_div0,
    output logic                        err_illegal
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic                        s1_vld_q, s1_vld_d;
    opcode_t                     s1_opc_q, s1_opc_d;
    logic signed [OPERAND_W-1:0] s1_a_q, s1_a_d;
    logic signed [OPERAND_W-1:0] s1_b_q, s1_b_d;
    logic [IDX_W-1:0]            s1_addr_q, s1_addr_d;

    logic [ADDR_W-1:0]           wr_cnt_q, wr_cnt_d;
    instruction_t                mem_q [DEPTH];
    instruction_t                mem_d [DEPTH];
    logic [DEPTH-1:0]            vld_q, vld_d;

    instruction_t                word_q, word_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        rd_ev_q, rd_ev_d;
    logic                        div0_q, div0_d;
    logic                        ill_q, ill_d;

    logic signed [RESULT_W-1:0]  alu_rslt;
    logic                        alu_div0;
    logic                        alu_ill;

    logic                        wp_ok;
    logic                        rp_ok;
    logic                        accept;
    logic [ADDR_W-1:0]           tgt;
    logic [IDX_W-1:0]            rd_idx;
    instruction_t                new_word;

    ir_alu #(
        .OPERAND_W (OPERAND_W),
        .RESULT_W  (RESULT_W)
    ) u_alu (
        .opc     (s1_opc_q),
        .op_a    (s1_a_q),
        .op_b    (s1_b_q),
        .rslt    (alu_rslt),
        .div0    (alu_div0),
        .illegal (alu_ill)
    );

    // Stage 1: address selection and capture.
    always_comb begin
        wp_ok     = {1'b0, write_pointer} < DEPTH_W;
        tgt       = wr_mode ? wr_cnt_q : write_pointer;
        accept    = load_en && (wr_mode || wp_ok);
        s1_vld_d  = accept;
        s1_opc_d  = s1_opc_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_addr_d = s1_addr_q;
        if (accept) begin
            s1_opc_d  = opcode;
            s1_a_d    = operand_a;
            s1_b_d    = operand_b;
            s1_addr_d = IDX_W'(tgt);
        end
        wr_cnt_d = wr_cnt_q;
        if (load_en && wr_mode) begin
            wr_cnt_d = (wr_cnt_q == LAST) ? '0 : wr_cnt_q + 1'b1;
        end
    end

    // Stage 2 write; reads index the post-write array to get the bypass.
    always_comb begin
        new_word.opc  = s1_opc_q;
        new_word.op_a = s1_a_q;
        new_word.op_b = s1_b_q;
        new_word.rslt = alu_rslt;
        mem_d = mem_q;
        vld_d = vld_q;
        if (s1_vld_q) begin
            mem_d[s1_addr_q] = new_word;
            vld_d[s1_addr_q] = 1'b1;
        end
        rp_ok      = {1'b0, read_pointer} < DEPTH_W;
        rd_idx     = IDX_W'(read_pointer);
        rd_valid_d = read_en;
        rd_ev_d    = rd_ev_q;
        word_d     = word_q;
        if (read_en) begin
            rd_ev_d = rp_ok && vld_d[rd_idx];
            word_d  = (rp_ok && vld_d[rd_idx]) ? mem_d[rd_idx] : '0;
        end
        div0_d = div0_q | (s1_vld_q & alu_div0);
        ill_d  = ill_q | (s1_vld_q & alu_ill)
               | (load_en & ~wr_mode & ~wp_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q   <= 1'b0;
            wr_cnt_q   <= '0;
            vld_q      <= '0;
            word_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_ev_q    <= 1'b0;
            div0_q     <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            wr_cnt_q   <= wr_cnt_d;
            vld_q      <= vld_d;
            word_q     <= word_d;
            rd_valid_q <= rd_valid_d;
            rd_ev_q    <= rd_ev_d;
            div0_q     <= div0_d;
            ill_q      <= ill_d;
        end
    end

    // Payload storage needs no reset: entries are qualified by vld_q.
    always_ff @(posedge clk) begin
        s1_opc_q  <= s1_opc_d;
        s1_a_q    <= s1_a_d;
        s1_b_q    <= s1_b_d;
        s1_addr_q <= s1_addr_d;
        mem_q     <= mem_d;
    end

    assign instruction_word = word_q;
    assign rd_valid         = rd_valid_q;
    assign rd_entry_valid   = rd_ev_q;
    assign wr_cnt           = wr_cnt_q;
    assign err_div0         = div0_q;
    assign err_illegal      = ill_q;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Randomised bench for instr_register_pipe against a transaction-level model.
// ADDR_W is widened to 6 so out-of-range pointers can be driven.
module tb_instr_register_pipe;
    import instr_register_pipe_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_en;
    logic              wr_mode;
    opcode_t           opcode;
    logic signed [31:0] operand_a;
    logic signed [31:0] operand_b;
    logic [AW-1:0]     write_pointer;
    logic              read_en;
    logic [AW-1:0]     read_pointer;
    instruction_t      instruction_word;
    logic              rd_valid;
    logic              rd_entry_valid;
    logic [AW-1:0]     wr_cnt;
    logic              err_div0;
    logic              err_illegal;

    always #5 clk = ~clk;

    instr_register_pipe #(
        .DEPTH     (DEPTH),
        .OPERAND_W (32),
        .RESULT_W  (64),
        .ADDR_W    (AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .load_en          (load_en),
        .wr_mode          (wr_mode),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .write_pointer    (write_pointer),
        .read_en          (read_en),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .rd_valid         (rd_valid),
        .rd_entry_valid   (rd_entry_valid),
        .wr_cnt           (wr_cnt),
        .err_div0         (err_div0),
        .err_illegal      (err_illegal)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input logic [191:0] got,
                       input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        int           addr;
        instruction_t w;
        bit           dz;
        bit           il;
    } pend_t;

    pend_t        pend[$];
    instruction_t m_mem[DEPTH];
    bit           m_val[DEPTH];
    int           m_wr;
    bit           m_dz;
    bit           m_il;
    instruction_t e_word;
    bit           e_rv;
    bit           e_ev;
    bit           live = 1'b0;
    int           cyc_n = 0;

    function automatic void model_op(input logic [3:0] opc,
                                     input logic signed [31:0] a,
                                     input logic signed [31:0] b,
                                     output longint r, output bit dz,
                                     output bit il);
        longint ax;
        longint bx;
        ax = a;
        bx = b;
        r  = 0;
        dz = 0;
        il = 0;
        case (opc)
            4'd0: r = 0;
            4'd1: r = ax;
            4'd2: r = bx;
            4'd3: r = ax + bx;
            4'd4: r = ax - bx;
            4'd5: r = ax * bx;
            4'd6: if (bx == 0) dz = 1; else r = ax / bx;
            4'd7: if (bx == 0) dz = 1; else r = ax % bx;
            default: il = 1;
        endcase
`ifdef IR_SATURATE_EN
        if (opc inside {4'd3, 4'd4, 4'd5}) begin
            if (r > 64'sh0000_0000_7FFF_FFFF) begin
                r  = 64'sh0000_0000_7FFF_FFFF;
                il = 1;
            end else if (r < 64'shFFFF_FFFF_8000_0000) begin
                r  = 64'shFFFF_FFFF_8000_0000;
                il = 1;
            end
        end
`endif
    endfunction

    always @(posedge clk) begin
        cyc_n++;
        if (reset) begin
            foreach (m_val[i]) m_val[i] = 0;
            pend.delete();
            m_wr   = 0;
            m_dz   = 0;
            m_il   = 0;
            e_word = '0;
            e_rv   = 0;
            e_ev   = 0;
            live   = 1;
        end else if (live) begin
            while (pend.size() > 0 && pend[0].due == cyc_n) begin
                pend_t p;
                p = pend.pop_front();
                m_mem[p.addr] = p.w;
                m_val[p.addr] = 1;
                m_dz = m_dz | p.dz;
                m_il = m_il | p.il;
            end
            e_rv = read_en;
            if (read_en) begin
                if (int'(read_pointer) >= DEPTH) begin
                    e_ev   = 0;
                    e_word = '0;
                end else begin
                    e_ev   = m_val[read_pointer];
                    e_word = e_ev ? m_mem[read_pointer] : '0;
                end
            end
            if (load_en) begin
                if (!wr_mode && int'(write_pointer) >= DEPTH) begin
                    m_il = 1;
                end else begin
                    pend_t  p;
                    longint r;
                    p.due    = cyc_n + 1;
                    p.addr   = wr_mode ? m_wr : int'(write_pointer);
                    model_op(opcode, operand_a, operand_b, r, p.dz, p.il);
                    p.w.opc  = opcode;
                    p.w.op_a = operand_a;
                    p.w.op_b = operand_b;
                    p.w.rslt = r;
                    pend.push_back(p);
                    if (wr_mode) m_wr = (m_wr + 1) % DEPTH;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (live) begin
            cmp("rd_valid", rd_valid, e_rv);
            if (e_rv) cmp("rd_entry_valid", rd_entry_valid, e_ev);
            cmp("instruction_word", instruction_word, e_word);
            cmp("wr_cnt", wr_cnt, AW'(m_wr));
            cmp("err_div0", err_div0, m_dz);
            cmp("err_illegal", err_illegal, m_il);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit ld, input bit wm, input logic [3:0] opc,
                         input logic signed [31:0] a,
                         input logic signed [31:0] b,
                         input int wp, input bit rd, input int rp);
        load_en       = ld;
        wr_mode       = wm;
        opcode        = opcode_t'(opc);
        operand_a     = a;
        operand_b     = b;
        write_pointer = AW'(wp);
        read_en       = rd;
        read_pointer  = AW'(rp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 4'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int rp);
        drive(0, 0, 4'd0, 0, 0, 0, 1, rp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        load_en       = 1'b0;
        wr_mode       = 1'b0;
        opcode        = ZERO;
        operand_a     = '0;
        operand_b     = '0;
        write_pointer = '0;
        read_en       = 1'b0;
        read_pointer  = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Post-reset state.
        cmp("rst_wr_cnt", wr_cnt, 0);
        cmp("rst_div0", err_div0, 0);
        cmp("rst_illegal", err_illegal, 0);
        for (int i = 0; i < DEPTH; i++) begin
            rd(i);
            cmp("rst_entry_valid", rd_entry_valid, 0);
            cmp("rst_word", instruction_word, 0);
        end

        // 33 auto-addressed ADD loads wrap onto entry 0.
        for (int i = 0; i < 33; i++) drive(1, 1, 4'd3, 5, -7, 0, 0, 0);
        idle();
        idle();
        cmp("wrap_wr_cnt", wr_cnt, 1);
        for (int i = 0; i < DEPTH; i++) begin
            rd(i);
            cmp("add_entry_valid", rd_entry_valid, 1);
            cmp("add_rslt", $unsigned(instruction_word.rslt),
                64'hFFFF_FFFF_FFFF_FFFE);
        end

        // Back-to-back loads to one address: later one wins.
        drive(1, 0, 4'd1, 11, 0, 7, 0, 0);
        drive(1, 0, 4'd1, 22, 0, 7, 0, 0);
        idle();
        rd(7);
        cmp("b2b_rslt", $unsigned(instruction_word.rslt), 64'd22);

        // MULT with same-edge bypass read.
        drive(1, 0, 4'd5, 32'h7FFF_FFFF, 2, 3, 0, 0);
        cmp("byp_rd_valid_pre", rd_valid, 0);
        rd(3);
        cmp("byp_rd_valid", rd_valid, 1);
`ifdef IR_SATURATE_EN
        cmp("byp_rslt", $unsigned(instruction_word.rslt),
            64'h0000_0000_7FFF_FFFF);
`else
        cmp("byp_rslt", $unsigned(instruction_word.rslt),
            64'h0000_0000_FFFF_FFFE);
        cmp("byp_model", $unsigned(e_word.rslt), 64'h0000_0000_FFFF_FFFE);
`endif
        idle();
        cmp("byp_rd_valid_post", rd_valid, 0);

        // DIV by zero then MOD.
        drive(1, 0, 4'd6, 9, 0, 4, 0, 0);
        drive(1, 0, 4'd7, -7, 2, 5, 0, 0);
        idle();
        rd(4);
        cmp("div0_rslt", $unsigned(instruction_word.rslt), 64'd0);
        cmp("div0_flag", err_div0, 1);
        rd(5);
        cmp("mod_rslt", $unsigned(instruction_word.rslt),
            64'hFFFF_FFFF_FFFF_FFFF);
        cmp("mod_model", $unsigned(e_word.rslt), 64'hFFFF_FFFF_FFFF_FFFF);
        idle();
        cmp("div0_sticky", err_div0, 1);

        // Reserved opcode.
        do_reset();
        drive(1, 0, 4'hC, 3, 4, 6, 0, 0);
        idle();
        cmp("rsvd_illegal", err_illegal, 1);
        rd(6);
        cmp("rsvd_entry_valid", rd_entry_valid, 1);
        cmp("rsvd_rslt", $unsigned(instruction_word.rslt), 64'd0);

        // Out-of-range write pointer is dropped.
        do_reset();
        drive(1, 0, 4'd1, 77, 0, 9, 0, 0);
        idle();
        drive(1, 0, 4'd1, 55, 0, 40, 0, 0);
        cmp("oor_illegal", err_illegal, 1);
        idle();
        idle();
        rd(8);
        cmp("oor_alias_valid", rd_entry_valid, 0);
        rd(9);
        cmp("oor_keep", $unsigned(instruction_word.rslt), 64'd77);
        rd(40);
        cmp("oor_read_valid", rd_entry_valid, 0);
        cmp("oor_read_word", instruction_word, 0);
        cmp("oor_wr_cnt", wr_cnt, 0);

        // Reset one cycle after load_en cancels the write.
        do_reset();
        drive(1, 1, 4'd6, 1, 0, 0, 0, 0);
        idle();
        idle();
        cmp("pre_rst_div0", err_div0, 1);
        drive(1, 1, 4'd3, 1, 2, 0, 0, 0);
        do_reset();
        idle();
        rd(1);
        cmp("flight_entry_valid", rd_entry_valid, 0);
        rd(0);
        cmp("flight_entry0_valid", rd_entry_valid, 0);
        cmp("flight_wr_cnt", wr_cnt, 0);
        cmp("flight_div0", err_div0, 0);
        cmp("flight_illegal", err_illegal, 0);

`ifdef IR_SATURATE_EN
        drive(1, 0, 4'd3, 32'h7FFF_FFFF, 1, 2, 0, 0);
        idle();
        rd(2);
        cmp("sat_rslt", $unsigned(instruction_word.rslt),
            64'h0000_0000_7FFF_FFFF);
        cmp("sat_illegal", err_illegal, 1);
`endif

        // Randomised traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [3:0]         opc;
            logic signed [31:0] a;
            logic signed [31:0] b;
            opc = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7))
                                             : 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 1) == 0) ? 32'($urandom)
                                            : 32'($urandom_range(0, 20)) - 10;
            b = ($urandom_range(0, 7) == 0) ? 32'sd0
              : ($urandom_range(0, 1) == 0) ? 32'($urandom)
                                            : 32'($urandom_range(0, 20)) - 10;
            reset = ($urandom_range(0, 127) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, opc,
                  a, b, $urandom_range(0, 40), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 40));
        end
        reset = 1'b0;
        idle();
        idle();
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
